// File: rtl/modulate_ctrl_pkg.sv
// Shared definitions for the modulate controller: register map, CTRL field
// positions and the sequencing FSM state encoding.
package modulate_ctrl_pkg;

    localparam logic [2:0] ADDR_CTRL        = 3'd0;
    localparam logic [2:0] ADDR_FM_CF       = 3'd1;
    localparam logic [2:0] ADDR_AM_CF       = 3'd2;
    localparam logic [2:0] ADDR_MOVE_FRE    = 3'd3;
    localparam logic [2:0] ADDR_DEEP        = 3'd4;
    localparam logic [2:0] ADDR_SWEEP_STEP  = 3'd5;
    localparam logic [2:0] ADDR_SWEEP_STOP  = 3'd6;
    localparam logic [2:0] ADDR_SWEEP_DWELL = 3'd7;

    localparam int NUM_REGS          = 8;
    localparam int CTRL_SEL_LSB      = 0;
    localparam int CTRL_SEL_MSB      = 2;
    localparam int CTRL_SWEEP_EN_BIT = 3;
    localparam int SEL_FM_BIT        = 1;
    localparam int DEEP_WIDTH        = 16;
    localparam int DWELL_WIDTH       = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUTE = 2'd1,
        ST_LOAD = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

endpackage

// File: rtl/modulate_sweep_gen.sv
// Linear carrier sweep: holds each value for dwell+1 enabled cycles, then adds
// step, falling back to the latched start on carry-out or on reaching stop.
module modulate_sweep_gen
    import modulate_ctrl_pkg::*;
#(
    parameter int PHASE_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [PHASE_WIDTH-1:0] start,
    input  logic [PHASE_WIDTH-1:0] step,
    input  logic [PHASE_WIDTH-1:0] stop,
    input  logic [DWELL_WIDTH-1:0] dwell,
    input  logic                   enable,
    output logic [PHASE_WIDTH-1:0] cur
);

    logic [PHASE_WIDTH-1:0] start_reg;
    logic [PHASE_WIDTH-1:0] cur_reg;
    logic [DWELL_WIDTH-1:0] dwell_cnt_reg;
    logic [PHASE_WIDTH:0]   sum_wide;
    logic                   wrap;

    // The extra top bit of the sum is the modulo-2^N carry.
    assign sum_wide = {1'b0, cur_reg} + {1'b0, step};
    assign wrap     = sum_wide[PHASE_WIDTH] || (sum_wide[PHASE_WIDTH-1:0] >= stop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_reg     <= '0;
            cur_reg       <= '0;
            dwell_cnt_reg <= '0;
        end else if (load) begin
            start_reg     <= start;
            cur_reg       <= start;
            dwell_cnt_reg <= '0;
        end else if (enable) begin
            if (dwell_cnt_reg == dwell) begin
                dwell_cnt_reg <= '0;
                cur_reg       <= wrap ? start_reg : sum_wide[PHASE_WIDTH-1:0];
            end else begin
                dwell_cnt_reg <= dwell_cnt_reg + 1'b1;
            end
        end
    end

    assign cur = cur_reg;

endmodule

// File: rtl/modulate_ctrl.sv
// Shadow register bank plus mute/settle/load sequencer for the AM/FM modulator.
// Register data is taken from the low bits of wr_data (PHASE_WIDTH <= 32).
module modulate_ctrl
    import modulate_ctrl_pkg::*;
#(
    parameter int PHASE_WIDTH   = 32,
    parameter int INPUT_WIDTH   = 12,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                               clk_in,
    input  logic                               RST,
    input  logic                               wr_en,
    input  logic [2:0]                         wr_addr,
    input  logic [31:0]                        wr_data,
    input  logic                               commit,
    output logic                               busy,
    output logic                               done,
    output logic                               mod_rst_n,
    output logic [2:0]                         Sel,
    output logic [PHASE_WIDTH-1:0]             FM_Center_Fre,
    output logic [PHASE_WIDTH-1:0]             AM_Center_Fre,
    output logic [PHASE_WIDTH-INPUT_WIDTH-1:0] move_fre,
    output logic [DEEP_WIDTH-1:0]              module_deep
);

    localparam int MOVE_WIDTH = PHASE_WIDTH - INPUT_WIDTH;
    localparam int SETTLE_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

    logic [NUM_REGS-1:0]    wr_hit;
    logic [2:0]             sh_sel_reg;
    logic                   sh_sweep_en_reg;
    logic [PHASE_WIDTH-1:0] sh_fm_cf_reg, sh_am_cf_reg, sh_step_reg, sh_stop_reg;
    logic [MOVE_WIDTH-1:0]  sh_move_reg;
    logic [DEEP_WIDTH-1:0]  sh_deep_reg;
    logic [DWELL_WIDTH-1:0] sh_dwell_reg;

    logic [2:0]             sel_reg;
    logic                   sweep_en_reg;
    logic [PHASE_WIDTH-1:0] fm_cf_reg, am_cf_reg, step_reg, stop_reg;
    logic [MOVE_WIDTH-1:0]  move_reg;
    logic [DEEP_WIDTH-1:0]  deep_reg;
    logic [DWELL_WIDTH-1:0] dwell_reg;

    state_t                 state_reg, state_next;
    logic [SETTLE_W-1:0]    settle_cnt_reg, settle_cnt_next;
    logic                   pending_reg, pending_next;
    logic                   done_reg, done_next;
    logic                   commit_reg;
    logic                   load_pulse;
    logic [PHASE_WIDTH-1:0] sweep_start;
    logic [PHASE_WIDTH-1:0] sweep_cur;

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_wr_hit
            assign wr_hit[gi] = wr_en && (wr_addr == 3'(gi));
        end
    endgenerate

    always_ff @(posedge clk_in or negedge RST) begin
        if (!RST) begin
            sh_sel_reg      <= '0;
            sh_sweep_en_reg <= 1'b0;
            sh_fm_cf_reg    <= '0;
            sh_am_cf_reg    <= '0;
            sh_move_reg     <= '0;
            sh_deep_reg     <= '0;
            sh_step_reg     <= '0;
            sh_stop_reg     <= '0;
            sh_dwell_reg    <= '0;
        end else begin
            if (wr_hit[ADDR_CTRL]) begin
                sh_sel_reg      <= wr_data[CTRL_SEL_MSB:CTRL_SEL_LSB];
                sh_sweep_en_reg <= wr_data[CTRL_SWEEP_EN_BIT];
            end
            if (wr_hit[ADDR_FM_CF])        sh_fm_cf_reg <= wr_data[PHASE_WIDTH-1:0];
            if (wr_hit[ADDR_AM_CF])        sh_am_cf_reg <= wr_data[PHASE_WIDTH-1:0];
            if (wr_hit[ADDR_MOVE_FRE])     sh_move_reg  <= wr_data[MOVE_WIDTH-1:0];
            if (wr_hit[ADDR_DEEP])         sh_deep_reg  <= wr_data[DEEP_WIDTH-1:0];
            if (wr_hit[ADDR_SWEEP_STEP])   sh_step_reg  <= wr_data[PHASE_WIDTH-1:0];
            if (wr_hit[ADDR_SWEEP_STOP])   sh_stop_reg  <= wr_data[PHASE_WIDTH-1:0];
            if (wr_hit[ADDR_SWEEP_DWELL])  sh_dwell_reg <= wr_data[DWELL_WIDTH-1:0];
        end
    end

    assign load_pulse = (state_reg == ST_LOAD);

    always_ff @(posedge clk_in or negedge RST) begin
        if (!RST) begin
            sel_reg      <= '0;
            sweep_en_reg <= 1'b0;
            fm_cf_reg    <= '0;
            am_cf_reg    <= '0;
            move_reg     <= '0;
            deep_reg     <= '0;
            step_reg     <= '0;
            stop_reg     <= '0;
            dwell_reg    <= '0;
        end else if (load_pulse) begin
            sel_reg      <= sh_sel_reg;
            sweep_en_reg <= sh_sweep_en_reg;
            fm_cf_reg    <= sh_fm_cf_reg;
            am_cf_reg    <= sh_am_cf_reg;
            move_reg     <= sh_move_reg;
            deep_reg     <= sh_deep_reg;
            step_reg     <= sh_step_reg;
            stop_reg     <= sh_stop_reg;
            dwell_reg    <= sh_dwell_reg;
        end
    end

    // Commit is registered first so the mute starts one edge after sampling.
    always_ff @(posedge clk_in or negedge RST) begin
        if (!RST) begin
            state_reg      <= ST_IDLE;
            settle_cnt_reg <= '0;
            pending_reg    <= 1'b0;
            done_reg       <= 1'b0;
            commit_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            settle_cnt_reg <= settle_cnt_next;
            pending_reg    <= pending_next;
            done_reg       <= done_next;
            commit_reg     <= commit;
        end
    end

    always_comb begin
        state_next      = state_reg;
        settle_cnt_next = settle_cnt_reg;
        pending_next    = pending_reg;
        done_next       = 1'b0;
        case (state_reg)
            ST_IDLE, ST_RUN: begin
                if (commit_reg) begin
                    state_next      = ST_MUTE;
                    settle_cnt_next = '0;
                end
            end
            ST_MUTE: begin
                if (commit_reg) pending_next = 1'b1;
                if (settle_cnt_reg == SETTLE_LAST) begin
                    state_next = ST_LOAD;
                end else begin
                    settle_cnt_next = settle_cnt_reg + 1'b1;
                end
            end
            ST_LOAD: begin
                // A commit seen while busy re-runs the whole mute sequence
                // without ever releasing the modulator or pulsing done.
                if (pending_reg || commit_reg) begin
                    state_next      = ST_MUTE;
                    settle_cnt_next = '0;
                    pending_next    = 1'b0;
                end else begin
                    state_next = ST_RUN;
                    done_next  = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign sweep_start = sh_sel_reg[SEL_FM_BIT] ? sh_fm_cf_reg : sh_am_cf_reg;

    modulate_sweep_gen #(
        .PHASE_WIDTH (PHASE_WIDTH)
    ) u_sweep (
        .clk    (clk_in),
        .rst_n  (RST),
        .load   (load_pulse),
        .start  (sweep_start),
        .step   (step_reg),
        .stop   (stop_reg),
        .dwell  (dwell_reg),
        .enable ((state_reg == ST_RUN) && sweep_en_reg),
        .cur    (sweep_cur)
    );

    assign busy          = (state_reg == ST_MUTE) || (state_reg == ST_LOAD);
    assign done          = done_reg;
    assign mod_rst_n     = (state_reg == ST_RUN);
    assign Sel           = sel_reg;
    assign FM_Center_Fre = sel_reg[SEL_FM_BIT] ? sweep_cur : fm_cf_reg;
    assign AM_Center_Fre = sel_reg[SEL_FM_BIT] ? am_cf_reg : sweep_cur;
    assign move_fre      = move_reg;
    assign module_deep   = deep_reg;

endmodule
